// File: rtl/comparador_feeder.sv
// Upstream feeder for the 8-bit comparador.
// It pairs bytes from a valid/ready stream into operands a and b and holds them on
// the comparador inputs. It registers the comparador result and returns it over a
// valid/ready output. It also keeps saturating counts of delivered pairs and of
// results equal to 1.
module comparador_feeder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_result,
  output logic [CNT_W-1:0]  pair_cnt,
  output logic [CNT_W-1:0]  ones_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load_a;
  logic               w_load_b;
  logic               w_sample;
  logic               w_handshake;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic               r_result;
  logic [CNT_W-1:0]   r_pair_cnt;
  logic [CNT_W-1:0]   r_ones_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= GET_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and update strobes; clear overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_sample    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      GET_A: begin
        if (in_valid) begin
          w_load_a    = 1'b1;
          w_state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (in_valid) begin
          w_load_b    = 1'b1;
          w_state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        w_sample    = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = GET_A;
        end
      end
      default: begin
        w_state_nxt = GET_A;
      end
    endcase
    if (clear) begin
      w_state_nxt = GET_A;
    end
  end

  // Operand and result registers; untouched while the result is being offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= 1'b0;
    end else if (clear) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= 1'b0;
    end else begin
      if (w_load_a) begin
        r_a <= in_data;
      end
      if (w_load_b) begin
        r_b <= in_data;
      end
      if (w_sample) begin
        r_result <= c;
      end
    end
  end

  // Saturating statistics, bumped only on a completed output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair_cnt <= '0;
      r_ones_cnt <= '0;
    end else if (clear) begin
      r_pair_cnt <= '0;
      r_ones_cnt <= '0;
    end else if (w_handshake) begin
      if (r_pair_cnt != CNT_MAX) begin
        r_pair_cnt <= r_pair_cnt + CNT_W'(1);
      end
      if (r_result && (r_ones_cnt != CNT_MAX)) begin
        r_ones_cnt <= r_ones_cnt + CNT_W'(1);
      end
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready   = (r_state == GET_A) || (r_state == GET_B);
  assign out_valid  = (r_state == HOLD);
  assign a          = r_a;
  assign b          = r_b;
  assign out_result = r_result;
  assign pair_cnt   = r_pair_cnt;
  assign ones_cnt   = r_ones_cnt;

endmodule

// File: tb/tb_comparador_feeder.sv
// Bench for comparador_feeder: a default-width instance plus a CNT_W=4 instance
// share one stimulus stream. The comparador stand-in is "a >= b".
module tb_comparador_feeder;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        c;
  logic        out_valid;
  logic        out_result;
  logic [15:0] pair_cnt;
  logic [15:0] ones_cnt;

  logic        sat_in_ready;
  logic [7:0]  sat_a;
  logic [7:0]  sat_b;
  logic        sat_c;
  logic        sat_out_valid;
  logic        sat_out_result;
  logic [3:0]  sat_pair_cnt;
  logic [3:0]  sat_ones_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pairs = 0;
  int exp_ones  = 0;

  assign c     = (a >= b);
  assign sat_c = (sat_a >= sat_b);

  comparador_feeder u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .pair_cnt(pair_cnt),
    .ones_cnt(ones_cnt)
  );

  comparador_feeder #(.DATA_W(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(sat_in_ready), .a(sat_a), .b(sat_b), .c(sat_c),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_result(sat_out_result),
    .pair_cnt(sat_pair_cnt), .ones_cnt(sat_ones_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat_val(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Offer one byte from a falling edge until it is taken; returns on a falling edge.
  task automatic push_byte(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL push_byte_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Send a full pair, capture what is offered at HOLD, then handshake after dly cycles.
  task automatic run_pair(input logic [7:0] da, input logic [7:0] db, input int dly,
                          output logic [7:0] oa, output logic [7:0] ob,
                          output logic orr, output logic ov);
    int n = 0;
    push_byte(da);
    push_byte(db);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    ov  = out_valid;
    oa  = a;
    ob  = b;
    orr = out_result;
    repeat (dly) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    exp_pairs++;
    if (da >= db) exp_ones++;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    exp_pairs = 0;
    exp_ones  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (a !== 8'h00) begin n_fail++; $display("FAIL reset_a: got %h want 00", a); end
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL reset_b: got %h want 00", b); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (pair_cnt !== 16'd0 || ones_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", pair_cnt, ones_cnt); end
    n_checks++; if (sat_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sat_in_ready: got %b want 1", sat_in_ready); end
    rst = 1'b0;
    @(negedge clk);
    // Reset while in SAMPLE (in_ready low) must return to GET_A asynchronously.
    push_byte(8'h99);
    push_byte(8'h98);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sample_in_ready: got %b want 0", in_ready); end
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || a !== 8'h00 || b !== 8'h00) begin n_fail++; $display("FAIL reset_in_sample: in_ready=%b a=%h b=%h want 1/00/00", in_ready, a, b); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pair();
    do_clear();
    out_ready = 1'b1;
    push_byte(8'h10);
    push_byte(8'h20);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b want 0", out_valid); end
    n_checks++; if (a !== 8'h10 || b !== 8'h20) begin n_fail++; $display("FAIL single_operands: got %h/%h want 10/20", a, b); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_latency: got %b want 1", out_valid); end
    n_checks++; if (out_result !== 1'b0) begin n_fail++; $display("FAIL single_result: got %b want 0", out_result); end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL single_after_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (pair_cnt !== 16'd1 || ones_cnt !== 16'd0) begin n_fail++; $display("FAIL single_counts: got %0d/%0d want 1/0", pair_cnt, ones_cnt); end
  endtask

  task automatic test_backpressure();
    do_clear();
    out_ready = 1'b0;
    push_byte(8'hFF);
    push_byte(8'h00);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || a !== 8'hFF || b !== 8'h00 || out_result !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b a=%h b=%h res=%b want 1/0/ff/00/1", i, out_valid, in_ready, a, b, out_result);
      end
      @(negedge clk);
    end
    n_checks++; if (pair_cnt !== 16'd0) begin n_fail++; $display("FAIL bp_no_count: got %0d want 0", pair_cnt); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || pair_cnt !== 16'd1 || ones_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_release: valid=%b cnt=%0d/%0d want 0/1/1", out_valid, pair_cnt, ones_cnt); end
    @(negedge clk);
    n_checks++; if (a !== 8'h33) begin n_fail++; $display("FAIL bp_held_byte: a=%h want 33", a); end
    in_valid = 1'b0;
    n_checks++; if (pair_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_single_hs: got %0d want 1", pair_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] da, db, oa, ob;
    logic orr, ov;
    do_clear();
    for (int i = 0; i < 40; i++) begin
      da = 8'($urandom);
      db = ($urandom_range(0, 3) == 0) ? da : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_pair(da, db, $urandom_range(0, 3), oa, ob, orr, ov);
      n_checks++;
      if (ov !== 1'b1 || oa !== da || ob !== db || orr !== (da >= db)) begin
        n_fail++;
        $display("FAIL rand_pair_%0d: valid=%b a=%h b=%h res=%b want 1/%h/%h/%b", i, ov, oa, ob, orr, da, db, (da >= db));
      end
      n_checks++;
      if (pair_cnt !== 16'(exp_pairs) || ones_cnt !== 16'(exp_ones)) begin
        n_fail++;
        $display("FAIL rand_counts_%0d: got %0d/%0d want %0d/%0d", i, pair_cnt, ones_cnt, exp_pairs, exp_ones);
      end
      n_checks++;
      if (sat_pair_cnt !== 4'(sat_val(exp_pairs, 15)) || sat_ones_cnt !== 4'(sat_val(exp_ones, 15))) begin
        n_fail++;
        $display("FAIL rand_sat_counts_%0d: got %0d/%0d want %0d/%0d", i, sat_pair_cnt, sat_ones_cnt, sat_val(exp_pairs, 15), sat_val(exp_ones, 15));
      end
    end
    n_checks++; if (sat_out_result !== 1'b0 && sat_out_result !== 1'b1) begin n_fail++; $display("FAIL rand_sat_result_known: got %b", sat_out_result); end
  endtask

  task automatic test_saturation();
    logic [7:0] x, oa, ob;
    logic orr, ov;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      run_pair(x, x, 0, oa, ob, orr, ov);
      n_checks++;
      if (orr !== 1'b1 || sat_pair_cnt !== 4'(sat_val(exp_pairs, 15)) || sat_ones_cnt !== 4'(sat_val(exp_ones, 15))) begin
        n_fail++;
        $display("FAIL sat_step_%0d: res=%b cnt=%0d/%0d want 1/%0d/%0d", i, orr, sat_pair_cnt, sat_ones_cnt, sat_val(exp_pairs, 15), sat_val(exp_ones, 15));
      end
    end
    n_checks++; if (sat_pair_cnt !== 4'd15 || sat_ones_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_final: got %0d/%0d want 15/15", sat_pair_cnt, sat_ones_cnt); end
    n_checks++; if (pair_cnt !== 16'd20 || ones_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_wide_final: got %0d/%0d want 20/20", pair_cnt, ones_cnt); end
  endtask

  task automatic test_clear_mid_pair();
    logic [7:0] oa, ob;
    logic orr, ov;
    do_clear();
    push_byte(8'h55);
    n_checks++; if (a !== 8'h55) begin n_fail++; $display("FAIL clr_mid_load: a=%h want 55", a); end
    do_clear();
    n_checks++; if (a !== 8'h00 || in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_mid_state: a=%h in_ready=%b want 00/1", a, in_ready); end
    run_pair(8'h01, 8'h02, 0, oa, ob, orr, ov);
    n_checks++; if (ov !== 1'b1 || oa !== 8'h01 || ob !== 8'h02 || orr !== 1'b0) begin n_fail++; $display("FAIL clr_mid_pair: valid=%b a=%h b=%h res=%b want 1/01/02/0", ov, oa, ob, orr); end
    n_checks++; if (pair_cnt !== 16'd1 || ones_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_mid_counts: got %0d/%0d want 1/0", pair_cnt, ones_cnt); end
  endtask

  task automatic test_clear_collision();
    int n = 0;
    do_clear();
    push_byte(8'h30);
    push_byte(8'h30);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL coll_reach_hold: valid=%b want 1", out_valid); end
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear     = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (pair_cnt !== 16'd0 || ones_cnt !== 16'd0 || sat_pair_cnt !== 4'd0) begin n_fail++; $display("FAIL coll_counts: got %0d/%0d/%0d want 0/0/0", pair_cnt, ones_cnt, sat_pair_cnt); end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || a !== 8'h00 || out_result !== 1'b0) begin n_fail++; $display("FAIL coll_state: valid=%b ready=%b a=%h res=%b want 0/1/00/0", out_valid, in_ready, a, out_result); end
    push_byte(8'h07);
    n_checks++; if (a !== 8'h07 || in_ready !== 1'b1) begin n_fail++; $display("FAIL coll_restart: a=%h ready=%b want 07/1", a, in_ready); end
  endtask

  task automatic test_async_reset();
    logic [7:0] oa, ob;
    logic orr, ov;
    do_clear();
    run_pair(8'h05, 8'h04, 0, oa, ob, orr, ov);
    push_byte(8'h40);
    push_byte(8'h41);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || pair_cnt !== 16'd1) begin n_fail++; $display("FAIL arst_pre: valid=%b cnt=%0d want 1/1", out_valid, pair_cnt); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_flags: valid=%b ready=%b want 0/1", out_valid, in_ready); end
    n_checks++; if (a !== 8'h00 || b !== 8'h00 || pair_cnt !== 16'd0 || ones_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_regs: a=%h b=%h cnt=%0d/%0d want 00/00/0/0", a, b, pair_cnt, ones_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_pairs = 0;
    exp_ones  = 0;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_single_pair();
    test_backpressure();
    test_random();
    test_saturation();
    test_clear_mid_pair();
    test_clear_collision();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
